mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 108 ++++++++++
 tb/tb_mul_div_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit: mult/multu/div/divu run for a fixed cycle count, and mthi/mtlo write directly.
// Latency is MULT_CYCLES or DIV_CYCLES with Busy high for exactly that many cycles; mthi/mtlo complete in 0 busy cycles.
// There is no handshake. The E stage stalls on Busy, and new requests seen while in RUN are dropped.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MADop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic [31:0]       op_a;
  logic [31:0]       op_b;

  logic signed [63:0] a_sx, b_sx;
  logic [63:0]        prod_s, prod_u;
  logic [31:0]        a_mag, b_mag, sdivisor, udivisor;
  logic [31:0]        q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;
  logic               launch;

  assign a_sx   = {{32{op_a[31]}}, op_a};
  assign b_sx   = {{32{op_b[31]}}, op_b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, op_a} * {32'd0, op_b};

  // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the dividend.
  assign a_mag    = op_a[31] ? (32'd0 - op_a) : op_a;
  assign b_mag    = op_b[31] ? (32'd0 - op_b) : op_b;
  assign sdivisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign udivisor = (op_b == 32'd0) ? 32'd1 : op_b;
  assign q_mag    = a_mag / sdivisor;
  assign r_mag    = a_mag % sdivisor;
  assign quo_s    = (op_a[31] ^ op_b[31]) ? (32'd0 - q_mag) : q_mag;
  assign rem_s    = op_a[31] ? (32'd0 - r_mag) : r_mag;
  assign quo_u    = op_a / udivisor;
  assign rem_u    = op_a % udivisor;

  assign launch = Start && (MADop inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      HI    <= '0;
      LO    <= '0;
      Busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            op    <= MADop;
            op_a  <= A;
            op_b  <= B;
            cnt   <= (MADop == OP_MULT || MADop == OP_MULTU) ? CNT_W'(MULT_CYCLES)
                                                              : CNT_W'(DIV_CYCLES);
            state <= RUN;
            Busy  <= 1'b1;
          end else if (!Start && MADop == OP_MTHI) begin
            HI <= A;
          end else if (!Start && MADop == OP_MTLO) begin
            LO <= A;
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            Busy  <= 1'b0;
            case (op)
              OP_MULT:  {HI, LO} <= prod_s;
              OP_MULTU: {HI, LO} <= prod_u;
              OP_DIV:   if (op_b != 32'd0) begin HI <= rem_s; LO <= quo_s; end
              OP_DIVU:  if (op_b != 32'd0) begin HI <= rem_u; LO <= quo_u; end
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed corner cases plus random ops against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MADop;
  logic [31:0] A, B, HI, LO;
  logic        Busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] ref_hi = 32'd0;
  logic [31:0] ref_lo = 32'd0;

  always #5 clk = ~clk;

  mul_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MADop(MADop),
    .A(A), .B(B), .HI(HI), .LO(LO), .Busy(Busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural result: {HI,LO} after the op, given the current {HI,LO}.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd1: return sa * sb;
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 32'd0) return cur;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return cur;
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return cur;
    endcase
  endfunction

  // mode 0: quiet inputs during RUN; 1: random Start/MADop/A/B; 2: mtlo attempts.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [63:0] r;
    int n;
    n = (o <= 3'd2) ? MULT_CYCLES : DIV_CYCLES;
    r = ref_result(o, a, b, {ref_hi, ref_lo});
    Start = 1'b1; MADop = o; A = a; B = b;
    step();
    for (int i = 1; i <= n; i++) begin
      check("busy_run", {31'd0, Busy}, 32'd1);
      check("hi_hold", HI, ref_hi);
      check("lo_hold", LO, ref_lo);
      case (mode)
        0: begin Start = 1'b0; MADop = 3'd0; end
        1: begin Start = 1'($urandom); MADop = 3'($urandom); A = $urandom; B = $urandom; end
        default: begin Start = 1'b0; MADop = 3'd6; A = $urandom; end
      endcase
      step();
    end
    Start = 1'b0; MADop = 3'd0;
    {ref_hi, ref_lo} = r;
    check("busy_done", {31'd0, Busy}, 32'd0);
    check("hi_result", HI, ref_hi);
    check("lo_result", LO, ref_lo);
  endtask

  task automatic mt(input logic st, input logic [2:0] o, input logic [31:0] a);
    Start = st; MADop = o; A = a; B = $urandom;
    step();
    if (!st && o == 3'd5) ref_hi = a;
    else if (!st && o == 3'd6) ref_lo = a;
    Start = 1'b0; MADop = 3'd0;
    check("mt_busy", {31'd0, Busy}, 32'd0);
    check("mt_hi", HI, ref_hi);
    check("mt_lo", LO, ref_lo);
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    int          sel;

    reset = 1'b1; Start = 1'b0; MADop = 3'd0; A = 32'd0; B = 32'd0;
    #2;
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // mult/multu corner operands; first launch on first edge after reset release
    run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, 0);
    check("mult_hi_const", HI, 32'hFFFFFFFF);
    check("mult_lo_const", LO, 32'hFFFFFFFE);
    run_op(3'd2, 32'hFFFFFFFF, 32'h00000002, 0);
    check("multu_hi_const", HI, 32'h00000001);
    check("multu_lo_const", LO, 32'hFFFFFFFE);

    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 0);
    check("div_lo_const", LO, 32'hFFFFFFFD);
    check("div_hi_const", HI, 32'hFFFFFFFF);
    run_op(3'd4, 32'd7, 32'd2, 0);
    check("divu_lo_const", LO, 32'd3);
    check("divu_hi_const", HI, 32'd1);

    // divide by zero leaves preset HI/LO
    mt(1'b0, 3'd5, 32'h11111111);
    mt(1'b0, 3'd6, 32'h22222222);
    run_op(3'd3, $urandom, 32'd0, 1);
    check("dz_hi_const", HI, 32'h11111111);
    check("dz_lo_const", LO, 32'h22222222);
    run_op(3'd4, $urandom, 32'd0, 0);

    // mthi in IDLE, mtlo attempted during RUN
    mt(1'b0, 3'd5, 32'h12345678);
    check("mthi_const", HI, 32'h12345678);
    run_op(3'd1, $urandom, $urandom, 2);

    // ignored requests in IDLE
    mt(1'b1, 3'd5, 32'hDEADBEEF);
    mt(1'b1, 3'd6, 32'hCAFEF00D);
    mt(1'b1, 3'd0, 32'h0BADF00D);
    mt(1'b1, 3'd7, 32'h0BADF00D);
    mt(1'b0, 3'd1, 32'h55555555);
    mt(1'b0, 3'd3, 32'h55555555);
    mt(1'b0, 3'd7, 32'h55555555);

    // back-to-back, second op consuming the just-written HI/LO
    run_op(3'd1, $urandom, $urandom, 1);
    run_op(3'd4, ref_lo, ref_hi | 32'd1, 1);
    run_op(3'd3, ref_hi, ref_lo, 0);

    // reset in the middle of a mult
    Start = 1'b1; MADop = 3'd1; A = $urandom; B = $urandom;
    step();
    Start = 1'b0; MADop = 3'd0;
    step();
    step();
    reset = 1'b1;
    #1;
    ref_hi = 32'd0; ref_lo = 32'd0;
    check("midrst_hi", HI, 32'd0);
    check("midrst_lo", LO, 32'd0);
    check("midrst_busy", {31'd0, Busy}, 32'd0);
    step();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < MULT_CYCLES + 2; i++) begin
      step();
      check("postrst_hi", HI, 32'd0);
      check("postrst_lo", LO, 32'd0);
      check("postrst_busy", {31'd0, Busy}, 32'd0);
    end

    // random mix with corner operands
    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 2) begin
        mt(1'b0, (sel == 0) ? 3'd5 : 3'd6, $urandom);
      end else begin
        o = 3'($urandom_range(1, 4));
        a = $urandom;
        b = $urandom;
        if (sel == 2) b = 32'd0;
        if (sel == 3) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        if (sel == 4) b = 32'($urandom_range(1, 9));
        run_op(o, a, b, int'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
